// File: rtl/dff_pipeline_if.sv
// Handshake bundle for dff_pipeline: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy.
interface dff_pipeline_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           d;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           q;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport master (
        output flush, in_valid, d, out_ready,
        input  in_ready, out_valid, q, occupancy
    );

    modport slave (
        input  flush, in_valid, d, out_ready,
        output in_ready, out_valid, q, occupancy
    );
endinterface

// File: rtl/dff_pipeline.sv
// Stallable DEPTH-stage register pipeline with per-stage valid bits, bubble
// collapse, synchronous flush and valid/ready handshake on both ends.
module dff_pipeline #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           reset,
    dff_pipeline_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH:0]   rdy;
    logic [OCC_W-1:0] occ;

    // Stage i can load when any stage from i downward is empty or the consumer pops;
    // written flat so the chain has no self-referencing loop.
    always_comb begin
        rdy = '0;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            rdy[i] = bus.out_ready;
            for (int j = i; j < int'(DEPTH); j++) begin
                if (!valid_q[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy[0]) begin
            valid_d[0] = bus.in_valid;
            data_d[0]  = bus.d;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        // Flush only drops the valid bits; data keeps its stale contents.
        if (bus.flush) begin
            valid_d = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    // While reset is high, anything offered is accepted and then discarded by the reset.
    assign bus.in_ready  = reset ? bus.out_ready : (rdy[0] && !bus.flush);
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.q         = data_q[DEPTH-1];
    assign bus.occupancy = occ;
endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised multi-stage register pipeline, the successor to the single D flip-flop. It carries a WIDTH-bit word through DEPTH register stages with per-stage valid bits, valid/ready backpressure, bubble collapse and a synchronous flush. It sits between producer and consumer blocks wherever a fixed-latency, stallable delay line is needed, and is driven through the same interface style as the existing DFF.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- RESET_VAL, 0: value loaded into every data stage on reset; WIDTH bits.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- flush  in  1  synchronous pipeline clear; does not touch data registers.
- in_valid  in  1  d carries a word.
- in_ready  out  1  pipeline can accept d this cycle.
- d  in  WIDTH  input word.
- out_valid  out  1  q carries a word.
- out_ready  in  1  consumer takes q this cycle.
- q  out  WIDTH  output word, equal to the last stage data register.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1].
- Ready chain is combinational:
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage advance:
  - Stage i (i ≥ 1) loads data[i-1] and valid[i-1] when rdy[i] is 1.
  - Stage 0 loads d and in_valid when rdy[0] is 1.
  - A stage whose rdy is 0 holds data and valid unchanged.
- Bubble collapse: an empty stage always accepts from upstream, even while downstream is stalled. Gaps close during a stall.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is popped when out_valid && out_ready.
  - out_valid = valid[DEPTH-1]; q = data[DEPTH-1].
  - in_valid does not depend on in_ready. out_valid never depends on out_ready.
- Flush (flush = 1 and reset = 0):
  - All valid bits clear at the next edge.
  - in_ready is 0 during the flush cycle, so no word is accepted.
  - Data registers keep their values.
  - out_valid may be 1 during the flush cycle. A pop in that cycle is legal and is counted by the consumer.
- occupancy = popcount(valid[]), combinational from the registers. Range 0..DEPTH.
- Priority: reset > flush > normal advance.
- Stalled words are never lost or duplicated. Order is strictly FIFO.

## Timing
- Reset values, visible the cycle after reset is sampled high:
  - valid all 0.
  - data all RESET_VAL.
  - q = RESET_VAL, out_valid = 0, occupancy = 0.
  - in_ready = out_ready during reset-high cycles. Inputs presented while reset is high are discarded.
- Reset mid-operation: every word in flight is dropped at that edge. The pipeline restarts empty the next cycle.
- Latency:
  - A word accepted at edge N into an unstalled, empty pipe gives out_valid = 1 after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance to consumption.
  - Throughput is 1 word/clk while out_ready = 1.
- Full (occupancy = DEPTH) with out_ready = 0: in_ready = 0.
- Full with out_ready = 1: in_ready = 1, and simultaneous accept and pop leave occupancy unchanged.
- Empty: out_valid = 0; q still shows the stale data[DEPTH-1].
- DEPTH = 1:
  - in_ready = !valid[0] || out_ready.
  - Same-cycle pop and accept is allowed.
- flush and reset asserted together: reset behaviour applies.

## Test plan
- Reset with WIDTH=8, DEPTH=4, RESET_VAL=8'hA5: assert reset for 2 cycles with in_valid=1, d=8'hFF → q=8'hA5, out_valid=0, occupancy=0 throughout; no word emerges later.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles → out_valid first rises 3 cycles after the first acceptance edge; outputs are 01..08 in order, one per cycle; in_ready stays 1.
- Backpressure and collapse:
  - Push 8'h11, idle one cycle, push 8'h22, then hold out_ready=0 → gap closes and occupancy reaches 2 with valid[3:2]=2'b11.
  - Continue pushing → in_ready drops when occupancy=4.
  - Release out_ready → 11, 22, ... emerge in order with none lost.
- Flush mid-stream: with occupancy=3, assert flush for 1 cycle with in_valid=1, d=8'h77 → in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; 8'h77 never appears at q.
- Reset mid-operation: full pipe stalled, pulse reset for 1 cycle → next cycle occupancy=0, q=RESET_VAL; a subsequent push of 8'h3C emerges after normal latency.
- DEPTH=1, WIDTH=16: out_ready=1, push 16'hBEEF then 16'hCAFE back-to-back → each visible at q one cycle after acceptance; in_ready stays 1; full with out_ready=0 → in_ready=0.
